// File: rtl/pc_control.sv
// rtl/pc_control.sv - rv32i program-counter register and next-PC selector
// Optional hold input enabled by defining PC_CONTROL_STALL_EN.

module pc_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PC_CONTROL_STALL_EN
    input  logic        stall,
`endif
    input  logic [1:0]  PC_Sel,
    input  logic        branch,
    input  logic [31:0] Imm,
    input  logic [31:0] R_rs1,
    output logic [31:0] PC
);

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'b00,
        SEL_BR   = 2'b01,
        SEL_JAL  = 2'b10,
        SEL_JALR = 2'b11
    } pc_sel_e;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;

    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        pc_plus_imm = pc_q + Imm;
        jalr_sum    = R_rs1 + Imm;
        next_pc     = pc_plus4;
        case (pc_sel_e'(PC_Sel))
            SEL_SEQ:  next_pc = pc_plus4;
            SEL_BR:   next_pc = branch ? pc_plus_imm : pc_plus4;
            SEL_JAL:  next_pc = pc_plus_imm;
            // Only JALR forces halfword alignment; other targets load unchecked.
            SEL_JALR: next_pc = {jalr_sum[31:1], 1'b0};
            default:  next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d = next_pc;
`ifdef PC_CONTROL_STALL_EN
        if (stall) begin
            pc_d = pc_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - directed self-checking bench for pc_control

module tb_pc_control;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  PC_Sel;
    logic        branch;
    logic [31:0] Imm;
    logic [31:0] R_rs1;
    logic [31:0] PC;

    int checks;
    int failures;

    pc_control #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef PC_CONTROL_STALL_EN
        .stall  (stall),
`endif
        .PC_Sel (PC_Sel),
        .branch (branch),
        .Imm    (Imm),
        .R_rs1  (R_rs1),
        .PC     (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] sel, input logic br,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] exp);
        PC_Sel = sel;
        branch = br;
        Imm    = imm;
        R_rs1  = rs1;
        @(posedge clk);
        #1;
        check_eq(tag, PC, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        stall    = 1'b0;
        PC_Sel   = 2'b00;
        branch   = 1'b0;
        Imm      = 32'd0;
        R_rs1    = 32'd0;

        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", PC, 32'h0);
        @(posedge clk);
        #1 check_eq("reset_hold", PC, 32'h0);
        #2 rst_n = 1'b1;

        step("seq1", 2'b00, 1'b0, 32'd0, 32'd0, 32'd4);
        step("seq2", 2'b00, 1'b1, 32'd100, 32'h55, 32'd8);
        step("seq3", 2'b00, 1'b0, 32'd0, 32'd0, 32'd12);

        step("jalr_to4",   2'b11, 1'b0, 32'd0, 32'd4, 32'd4);
        step("br_taken1",  2'b01, 1'b1, 32'd10, 32'h999, 32'd14);
        step("br_taken2",  2'b01, 1'b1, 32'd10, 32'd0, 32'd24);
        step("jal_neg",    2'b10, 1'b1, -32'sd10, 32'h8000, 32'd14);
        step("jalr_imm0",  2'b11, 1'b0, 32'd0, 32'h8000, 32'h8000);
        step("jalr_bit0",  2'b11, 1'b1, 32'd1, 32'h8000, 32'h8000);
        step("br_not",     2'b01, 1'b0, -32'sh8000, 32'd0, 32'h8004);
        step("jal_back",   2'b10, 1'b0, -32'sh8000, 32'd0, 32'h4);
        step("jalr_top",   2'b11, 1'b0, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        step("seq_wrap",   2'b00, 1'b0, 32'd0, 32'd0, 32'h0);
        step("br_odd",     2'b01, 1'b1, 32'd3, 32'd0, 32'h3);
        step("jalr_negim", 2'b11, 1'b0, -32'sd3, 32'h100, 32'hFC);
        step("jal_wrap",   2'b10, 1'b0, 32'hFFFF_FF08, 32'd0, 32'h4);
        step("jalr_8004",  2'b11, 1'b0, 32'd4, 32'h8000, 32'h8004);

        PC_Sel = 2'b10;
        Imm    = 32'h40;
        #2 check_eq("mid_cycle_nochange", PC, 32'h8004);
        rst_n = 1'b0;
        #1 check_eq("reset_midrun", PC, 32'h0);
        #3 rst_n = 1'b1;
        step("after_reset", 2'b00, 1'b0, 32'd0, 32'd0, 32'd4);

`ifdef PC_CONTROL_STALL_EN
        stall = 1'b1;
        step("stall1", 2'b10, 1'b1, 32'h100, 32'd0, 32'd4);
        step("stall2", 2'b01, 1'b1, 32'h100, 32'd0, 32'd4);
        stall = 1'b0;
        step("unstall", 2'b10, 1'b0, 32'h100, 32'd0, 32'h104);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_eq("reset_over_stall", PC, 32'h0);
        #3 rst_n = 1'b1;
        stall = 1'b0;
        step("post_stall_seq", 2'b00, 1'b0, 32'd0, 32'd0, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
